// File: rtl/acc_pkg.sv
// Shared definitions for the accelerator fetch engine: FSM states, opcode field
// position and default bus widths.
package acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int OP_MSB     = 31;
    localparam int OP_LSB     = 26;
    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/acc_skid_buf.sv
// Two-entry FIFO between the data memory read port and the accelerator stream.
// Its owner must never push into a full buffer unless a pop happens the same cycle.
module acc_skid_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] entry [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic              push;
    logic              pop;

    assign out_valid = (count != 2'd0);
    assign out_data  = entry[rd_ptr];
    assign pop       = out_valid & out_ready;
    assign push      = in_valid & ((count != 2'd2) | pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                entry[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                entry[wr_ptr] <= in_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/acc_fetch_engine.sv
// Accelerator command consumer: streams datasize words from data memory to the accelerator.
// Optional stall timeout with abort is built when ACC_TIMEOUT_EN is defined.
module acc_fetch_engine
    import acc_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              accbypass,
    input  logic [31:0]       fullinstruction,
    input  logic [31:0]       startaddr,
    input  logic [31:0]       datasize,
    output logic              accdone,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [5:0]        acc_op,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              acc_err
);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] base;
    logic [31:0]       size;
    logic [31:0]       issued;
    logic [31:0]       accepted;
    logic              rd_pending;
    logic [1:0]        buf_count;
    logic [2:0]        occupancy;
    logic              pop;
    logic              can_issue;
    logic              timeout;
    logic              unused_bits;

    assign unused_bits = ^{startaddr[31:ADDR_W+2], startaddr[1:0], fullinstruction[OP_LSB-1:0]};

    // Buffer space is reserved for every read in flight, so a stalled consumer never loses data.
    assign pop       = out_valid & out_ready;
    assign occupancy = {1'b0, buf_count} + {2'b0, rd_pending} - {2'b0, pop};
    assign can_issue = (occupancy < 3'd2);
    assign mem_addr  = base + issued[ADDR_W-1:0];
    assign out_last  = out_valid & ((accepted + 32'd1) == size);

    acc_skid_buf #(
        .DATA_W(DATA_W)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .flush    (timeout),
        .in_valid (rd_pending),
        .in_data  (mem_rdata),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .count    (buf_count)
    );

    always_comb begin
        next_state = state;
        mem_rd     = 1'b0;
        accdone    = 1'b0;
        case (state)
            IDLE: begin
                if (!accbypass) begin
                    next_state = (datasize == 32'd0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (can_issue && !timeout) begin
                    mem_rd = 1'b1;
                    if ((issued + 32'd1) == size) begin
                        next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                accdone = 1'b1;
                if (accbypass) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (timeout) begin
            next_state = DONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            base       <= '0;
            size       <= '0;
            issued     <= '0;
            accepted   <= '0;
            acc_op     <= '0;
            rd_pending <= 1'b0;
        end else begin
            state      <= next_state;
            rd_pending <= mem_rd & ~timeout;
            if (state == IDLE && !accbypass) begin
                base     <= startaddr[ADDR_W+1:2];
                size     <= datasize;
                acc_op   <= fullinstruction[OP_MSB:OP_LSB];
                issued   <= '0;
                accepted <= '0;
            end else begin
                if (mem_rd) begin
                    issued <= issued + 32'd1;
                end
                if (pop) begin
                    accepted <= accepted + 32'd1;
                end
            end
        end
    end

`ifdef ACC_TIMEOUT_EN
    localparam logic [31:0] STALL_LIMIT = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] stall_cnt;
    logic        active;
    logic        stalled;

    assign active  = (state == FETCH) || (state == DRAIN);
    assign stalled = active & out_valid & ~out_ready;
    assign timeout = stalled & (stall_cnt == STALL_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            acc_err   <= 1'b0;
        end else begin
            if (!active || pop || timeout) begin
                stall_cnt <= '0;
            end else if (stalled) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (timeout) begin
                acc_err <= 1'b1;
            end else if (state == DONE && accbypass) begin
                acc_err <= 1'b0;
            end
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
    assign acc_err = 1'b0;
`endif

endmodule

// File: tb/tb_acc_fetch_engine.sv
// Self-checking bench for acc_fetch_engine: memory model plus address/data scoreboards
// filled when a command is driven and drained as the DUT reads and streams.
module tb_acc_fetch_engine;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              accbypass;
    logic [31:0]       fullinstruction;
    logic [31:0]       startaddr;
    logic [31:0]       datasize;
    logic              accdone;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [5:0]        acc_op;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;
    logic              acc_err;

    logic [31:0]       mem [64];
    logic [ADDR_W-1:0] addr_q [$];
    logic [32:0]       data_q [$];
    int                ready_mode = 0;
    int                checks = 0;
    int                errors = 0;

    acc_fetch_engine #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .accbypass      (accbypass),
        .fullinstruction(fullinstruction),
        .startaddr      (startaddr),
        .datasize       (datasize),
        .accdone        (accdone),
        .mem_rd         (mem_rd),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .acc_op         (acc_op),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_last       (out_last),
        .out_ready      (out_ready),
        .acc_err        (acc_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_rd) begin
            mem_rdata <= mem[mem_addr];
        end
    end

    // Consumer readiness: 0 = always ready, 1 = toggling, 2 = stalled.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: out_ready = ~out_ready;
                2: out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] saddr, input logic [31:0] size,
                                 input logic [5:0] op, input int mode);
        logic [ADDR_W-1:0] a;
        logic [32:0]       e;
        logic              lastf;
        int                first_rd;
        int                last_rd;
        int                first_valid;
        int                done_t;
        int                iss;
        int                acc;
        int                popn;
        addr_q.delete();
        data_q.delete();
        for (int i = 0; i < int'(size); i++) begin
            a = saddr[7:2] + i[5:0];
            lastf = (i == int'(size) - 1);
            addr_q.push_back(a);
            data_q.push_back({lastf, mem[a]});
        end
        $display("[TB] command addr=%0h size=%0d mode=%0d", saddr, size, mode);
        ready_mode      = mode;
        fullinstruction = {op, 26'h155_AAAA};
        startaddr       = saddr;
        datasize        = size;
        accbypass       = 1'b0;
        @(posedge clk);
        first_rd = -1; last_rd = -1; first_valid = -1; done_t = -1; iss = 0; acc = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            popn = (out_valid && out_ready) ? 1 : 0;
            if (mem_rd) begin
                if (first_rd < 0) first_rd = t;
                last_rd = t;
                checkOutput("outstanding", 32'((iss - acc - popn) < 2), 32'd1);
                checkOutput("rd_in_range", 32'(addr_q.size() != 0), 32'd1);
                if (addr_q.size() != 0) begin
                    checkOutput("rd_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
                end
                iss++;
            end
            if (out_valid && first_valid < 0) first_valid = t;
            if (popn == 1) begin
                checkOutput("word_in_range", 32'(data_q.size() != 0), 32'd1);
                if (data_q.size() != 0) begin
                    e = data_q.pop_front();
                    checkOutput("out_data", out_data, e[31:0]);
                    checkOutput("out_last", 32'(out_last), 32'(e[32]));
                end
                acc++;
            end
            if (t == 1) begin
                startaddr       = 32'hFFFF_FFFC;
                datasize        = 32'd50;
                fullinstruction = 32'hFFFF_FFFF;
            end
            if (accdone) begin
                done_t = t;
                break;
            end
        end
        checkOutput("accdone_seen", 32'(done_t >= 0), 32'd1);
        checkOutput("words_left", 32'(data_q.size()), 32'd0);
        checkOutput("reads_left", 32'(addr_q.size()), 32'd0);
        checkOutput("acc_op", 32'(acc_op), 32'(op));
        checkOutput("acc_err", 32'(acc_err), 32'd0);
        if (mode == 0) begin
            checkOutput("done_time", 32'(done_t), (size == 32'd0) ? 32'd0 : size + 32'd2);
            if (size != 32'd0) begin
                checkOutput("first_valid", 32'(first_valid), 32'd2);
                checkOutput("rd_span", 32'(last_rd - first_rd), size - 32'd1);
            end
        end
        @(negedge clk);
        checkOutput("accdone_hold", 32'(accdone), 32'd1);
        accbypass = 1'b1;
        @(negedge clk);
        checkOutput("accdone_fall", 32'(accdone), 32'd0);
        checkOutput("idle_no_rd", 32'(mem_rd), 32'd0);
        ready_mode = 0;
    endtask

    initial begin
        int done_t;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'hC0DE_0000 | (i * 7 + 3);
        end
        reset           = 1'b1;
        accbypass       = 1'b1;
        fullinstruction = '0;
        startaddr       = '0;
        datasize        = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_accdone", 32'(accdone), 32'd0);
        checkOutput("rst_mem_rd", 32'(mem_rd), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_acc_op", 32'(acc_op), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(32'h10, 32'd4, 6'h11, 0);
        applyStimulus(32'h00, 32'd0, 6'h12, 0);
        applyStimulus(32'hF8, 32'd4, 6'h13, 0);
        applyStimulus(32'h20, 32'd8, 6'h14, 1);

        // Reset in the middle of a fetch must clear outputs without waiting for a clock.
        fullinstruction = {6'h2A, 26'h0};
        startaddr       = 32'h40;
        datasize        = 32'd8;
        accbypass       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre_reset_rd", 32'(mem_rd), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("async_mem_rd", 32'(mem_rd), 32'd0);
        checkOutput("async_out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_accdone", 32'(accdone), 32'd0);
        checkOutput("async_acc_op", 32'(acc_op), 32'd0);
        checkOutput("async_mem_addr", 32'(mem_addr), 32'd0);
        accbypass = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(32'h04, 32'd3, 6'h15, 0);
        applyStimulus(32'hFC, 32'd5, 6'h16, 1);
        applyStimulus(32'h80, 32'd1, 6'h17, 0);

`ifdef ACC_TIMEOUT_EN
        fullinstruction = {6'h3C, 26'h0};
        startaddr       = 32'h0;
        datasize        = 32'd4;
        ready_mode      = 2;
        accbypass       = 1'b0;
        @(posedge clk);
        done_t = -1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (accdone) begin
                done_t = t;
                break;
            end
        end
        checkOutput("to_time", 32'(done_t), 32'd18);
        checkOutput("to_err", 32'(acc_err), 32'd1);
        checkOutput("to_flushed", 32'(out_valid), 32'd0);
        accbypass = 1'b1;
        @(negedge clk);
        checkOutput("to_done_clr", 32'(accdone), 32'd0);
        checkOutput("to_err_clr", 32'(acc_err), 32'd0);
        ready_mode = 0;
        @(negedge clk);
`else
        done_t = 0;
        checkOutput("err_tied", 32'(acc_err), 32'(done_t));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
